lms_top: RTL and testbench



---
 rtl/lms_top.sv | 181 ++++++++++++++++++
 tb/tb_lms_top.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_top.sv
// lms_top: adaptive LMS noise-cancellation core.
//
// Each accepted sample is handled in one pass. The step gain is formed first.
// Then each of the TAPS taps is visited once. At each tap the weight is updated
// from the previous reference vector, and the new weight is multiplied by the
// new reference vector into a 40-bit accumulator. The saturated sum is
// registered as the anti-noise output, and out_valid strobes for one cycle.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   in_valid        one-cycle input strobe, honoured only when idle
//   error_in        error sample e, Q1.15
//   feedforward_in  reference sample x, Q1.15
//   desired_in      desired sample d, Q1.15 (internal-error build only)
//   u_in            step size mu, Q1.15
//   out_sample      filter output y, Q2.30, held between strobes
//   out_valid       one-cycle strobe, out_sample is new
//
// Build option
//   LMS_INTERNAL_ERROR_EN  when defined, e = sat16(desired_in - y_prev), where
//                          y_prev is the previous output rescaled to Q1.15.
//                          In this build error_in is ignored. When undefined,
//                          e = error_in.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for in_valid; the sample inputs are latched on accept
// S_GAIN | g = sat16(mu*e >>> 15); the accumulator is cleared
// S_TAP  | tap k: weight update and MAC; the delay line shifts at the last tap
// S_OUT  | output register loaded, out_valid strobes

module lms_top #(
   parameter int TAPS = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic signed [15:0] error_in,
   input  logic signed [15:0] feedforward_in,
   input  logic signed [15:0] desired_in,
   input  logic signed [15:0] u_in,
   output logic signed [31:0] out_sample,
   output logic               out_valid
);

   localparam int              KW     = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [KW-1:0]   K_LAST = KW'(TAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_GAIN, S_TAP, S_OUT} state_t;

   function automatic logic signed [15:0] sat16(input logic signed [39:0] v);
      if (v > 40'sd32767)
         return 16'sh7fff;
      else if (v < -40'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   function automatic logic signed [31:0] sat32(input logic signed [39:0] v);
      if (v > 40'sd2147483647)
         return 32'sh7fffffff;
      else if (v < -40'sd2147483648)
         return 32'sh80000000;
      else
         return v[31:0];
   endfunction

   state_t             state_q;
   logic [KW-1:0]      k_q;
   logic signed [15:0] x_q [TAPS];
   logic signed [15:0] w_q [TAPS];
   logic signed [15:0] mu_q;
   logic signed [15:0] src_q;      // latched error source: error_in or desired_in
   logic signed [15:0] xin_q;
   logic signed [15:0] g_q;
   logic signed [39:0] acc_q;

   logic signed [15:0] src_sel;
   logic signed [15:0] e_eff;
   logic               unused_port;

`ifdef LMS_INTERNAL_ERROR_EN
   logic signed [15:0] y_prev_q;

   assign src_sel     = desired_in;
   assign unused_port = ^error_in;
   assign e_eff       = sat16(40'(src_q) - 40'(y_prev_q));
`else
   assign src_sel     = error_in;
   assign unused_port = ^desired_in;
   assign e_eff       = src_q;
`endif

   logic signed [15:0] x_old;
   logic signed [15:0] x_new;
   logic signed [15:0] w_old;
   logic signed [31:0] prod_ge;
   logic signed [31:0] prod_gx;
   logic signed [31:0] prod_wx;
   logic signed [15:0] g_d;
   logic signed [15:0] wn_d;
   logic signed [39:0] acc_d;

   // The update reads the old delay line, and the filter reads the new one.
   // The new vector is the old vector shifted by one, with the latched
   // sample at x[0]. This lets the shift wait until the last tap.
   always_comb begin
      x_old   = x_q[k_q];
      w_old   = w_q[k_q];
      x_new   = (k_q == '0) ? xin_q : x_q[k_q - 1'b1];
      prod_ge = 32'(mu_q) * 32'(e_eff);
      g_d     = sat16(40'(prod_ge >>> 15));
      prod_gx = 32'(g_q) * 32'(x_old);
      wn_d    = sat16(40'(w_old) + 40'(prod_gx >>> 15));
      prod_wx = 32'(wn_d) * 32'(x_new);
      acc_d   = acc_q + 40'(prod_wx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         mu_q       <= '0;
         src_q      <= '0;
         xin_q      <= '0;
         g_q        <= '0;
         acc_q      <= '0;
         out_sample <= '0;
         out_valid  <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            w_q[i] <= '0;
         end
`ifdef LMS_INTERNAL_ERROR_EN
         y_prev_q   <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  mu_q    <= u_in;
                  src_q   <= src_sel;
                  xin_q   <= feedforward_in;
                  state_q <= S_GAIN;
               end
            end
            S_GAIN: begin
               g_q     <= g_d;
               acc_q   <= '0;
               k_q     <= '0;
               state_q <= S_TAP;
            end
            S_TAP: begin
               w_q[k_q] <= wn_d;
               acc_q    <= acc_d;
               if (k_q == K_LAST) begin
                  x_q[0] <= xin_q;
                  for (int i = 1; i < TAPS; i++)
                     x_q[i] <= x_q[i-1];
                  state_q <= S_OUT;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            S_OUT: begin
               out_sample <= sat32(acc_q);
               out_valid  <= 1'b1;
`ifdef LMS_INTERNAL_ERROR_EN
               y_prev_q   <= sat16(acc_q >>> 15);
`endif
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lms_top.sv
// Directed bench for lms_top with the default build (TAPS = 128).
module tb_lms_top;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic signed [15:0] error_in;
   logic signed [15:0] feedforward_in;
   logic signed [15:0] desired_in;
   logic signed [15:0] u_in;
   logic signed [31:0] out_sample;
   logic               out_valid;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lms_top #(.TAPS(128)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .error_in       (error_in),
      .feedforward_in (feedforward_in),
      .desired_in     (desired_in),
      .u_in           (u_in),
      .out_sample     (out_sample),
      .out_valid      (out_valid)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Called at posedge+1. Returns at the posedge+1 after the capturing edge.
   task automatic send(input logic signed [15:0] mu, input logic signed [15:0] e,
                       input logic signed [15:0] x);
      u_in           = mu;
      error_in       = e;
      feedforward_in = x;
      desired_in     = 16'sd0;
      in_valid       = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_cycles(input int n, output int cnt, output int first,
                             output logic signed [31:0] last);
      cnt   = 0;
      first = -1;
      last  = '0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) begin
            cnt++;
            if (first < 0) first = i;
            last = out_sample;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid       = 1'b0;
      error_in       = '0;
      feedforward_in = '0;
      desired_in     = '0;
      u_in           = '0;
      rst_n          = 1'b0;
      #3;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
      else n_pass++;
      n_total++;
      if (out_sample !== 32'sd0) $display("FAIL reset_out_sample: got %0d want 0", out_sample);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_first_passes();
      int cnt, first;
      logic signed [31:0] last;
      send(16384, 16384, 16384);
      run_cycles(135, cnt, first, last);
      n_total++;
      if (cnt !== 1) $display("FAIL pass1_count: got %0d want 1", cnt);
      else n_pass++;
      n_total++;
      if (first !== 130) $display("FAIL pass1_latency: got %0d want 130", first);
      else n_pass++;
      n_total++;
      if (last !== 32'sd0) $display("FAIL pass1_value: got %0d want 0", last);
      else n_pass++;

      send(16384, 16384, 16384);
      run_cycles(135, cnt, first, last);
      n_total++;
      if (cnt !== 1 || first !== 130)
         $display("FAIL pass2_timing: got cnt %0d at %0d want 1 at 130", cnt, first);
      else n_pass++;
      n_total++;
      if (last !== 32'sd67108864) $display("FAIL pass2_value: got %0d want 67108864", last);
      else n_pass++;

      send(16384, 16384, 16384);
      run_cycles(135, cnt, first, last);
      n_total++;
      if (last !== 32'sd201326592) $display("FAIL pass3_value: got %0d want 201326592", last);
      else n_pass++;
      n_total++;
      if (out_valid !== 1'b0 || out_sample !== 32'sd201326592)
         $display("FAIL hold_value: got %0d valid %b want 201326592 valid 0", out_sample, out_valid);
      else n_pass++;
   endtask

   task automatic test_saturation();
      int cnt, first;
      logic signed [31:0] last;
      int exp_out [6] = '{0, 1073610755, 2147287044, 2147483647, 2147483647, 2147483647};
      do_reset();
      for (int p = 0; p < 6; p++) begin
         send(32767, 32767, 32767);
         run_cycles(135, cnt, first, last);
         n_total++;
         if (cnt !== 1 || last !== exp_out[p])
            $display("FAIL sat_pass%0d: got %0d (cnt %0d) want %0d", p, last, cnt, exp_out[p]);
         else n_pass++;
      end
   endtask

   task automatic test_drop_mid_pass();
      int c1, c2, f1, f2;
      logic signed [31:0] l1, l2;
      do_reset();
      send(16384, 16384, 16384);
      run_cycles(49, c1, f1, l1);
      send(16384, 16384, 8000);
      run_cycles(84, c2, f2, l2);
      n_total++;
      if (c1 + c2 !== 1) $display("FAIL drop_count: got %0d want 1", c1 + c2);
      else n_pass++;
      n_total++;
      if (l2 !== 32'sd0) $display("FAIL drop_value: got %0d want 0", l2);
      else n_pass++;
      send(16384, 16384, 16384);
      run_cycles(135, c1, f1, l1);
      n_total++;
      if (c1 !== 1 || l1 !== 32'sd67108864)
         $display("FAIL drop_delay_line: got %0d (cnt %0d) want 67108864", l1, c1);
      else n_pass++;
   endtask

   task automatic test_reset_mid_pass();
      int cnt, first;
      logic signed [31:0] last;
      do_reset();
      send(16384, 16384, 16384);
      run_cycles(135, cnt, first, last);
      send(16384, 16384, 16384);
      run_cycles(135, cnt, first, last);
      send(16384, 16384, 16384);
      run_cycles(59, cnt, first, last);
      #3;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (out_sample !== 32'sd0 || out_valid !== 1'b0)
         $display("FAIL midreset_clear: got %0d valid %b want 0 valid 0", out_sample, out_valid);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_cycles(140, cnt, first, last);
      n_total++;
      if (cnt !== 0) $display("FAIL midreset_no_valid: got %0d strobes want 0", cnt);
      else n_pass++;
      send(16384, 16384, 16384);
      run_cycles(135, cnt, first, last);
      n_total++;
      if (cnt !== 1 || last !== 32'sd0)
         $display("FAIL midreset_next: got %0d (cnt %0d) want 0", last, cnt);
      else n_pass++;
   endtask

   task automatic test_held_valid();
      int cnt = 0;
      int t1 = -1;
      int t2 = -1;
      logic signed [31:0] v2 = '0;
      do_reset();
      u_in           = 16384;
      error_in       = 16384;
      feedforward_in = 16384;
      in_valid       = 1'b1;
      for (int i = 0; i < 275; i++) begin
         @(posedge clk);
         #1;
         if (i == 139) in_valid = 1'b0;
         if (out_valid === 1'b1) begin
            cnt++;
            if (t1 < 0) t1 = i;
            else begin
               t2 = i;
               v2 = out_sample;
            end
         end
      end
      in_valid = 1'b0;
      n_total++;
      if (cnt !== 2) $display("FAIL held_count: got %0d want 2", cnt);
      else n_pass++;
      n_total++;
      if (t1 !== 130 || t2 !== 261)
         $display("FAIL held_timing: got %0d,%0d want 130,261", t1, t2);
      else n_pass++;
      n_total++;
      if (v2 !== 32'sd67108864) $display("FAIL held_value: got %0d want 67108864", v2);
      else n_pass++;
   endtask

   task automatic test_out_cycle_pulse();
      int cnt, first;
      logic signed [31:0] last;
      do_reset();
      send(16384, 16384, 16384);
      run_cycles(129, cnt, first, last);
      send(16384, 16384, 8000);
      n_total++;
      if (out_valid !== 1'b1 || out_sample !== 32'sd0)
         $display("FAIL outcycle_strobe: got %0d valid %b want 0 valid 1", out_sample, out_valid);
      else n_pass++;
      run_cycles(140, cnt, first, last);
      n_total++;
      if (cnt !== 0) $display("FAIL outcycle_dropped: got %0d strobes want 0", cnt);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_first_passes();
      test_saturation();
      test_drop_mid_pass();
      test_reset_mid_pass();
      test_held_valid();
      test_out_cycle_pulse();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
